// File: rtl/lock_grp_pkg.sv
// rtl/lock_grp_pkg.sv - shared types and helpers for the lock-grouped register array
package lock_grp_pkg;

  // Write-path FSM: COMMIT is the single back-pressure cycle after a successful write
  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } wr_state_e;

  // Lock group that owns a bank address
  function automatic int unsigned grp_of(input int unsigned addr, input int unsigned group_size);
    return addr / group_size;
  endfunction

endpackage

// File: rtl/lock_grp_ctrl.sv
// rtl/lock_grp_ctrl.sv - per-group sticky lock bit and write permit
module lock_grp_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_set,
  output logic lock_q,
  output logic permit
);

  // Lock is sticky: once set it only clears on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_q | lock_set;
    end
  end

  // A lock request in the same cycle already blocks the write
  assign permit = ~(lock_q | lock_set);

endmodule

// File: rtl/lock_grouped_reg_array.sv
// rtl/lock_grouped_reg_array.sv - bank registers gated by per-group sticky locks
module lock_grouped_reg_array #(
  parameter  int DATA_W     = 2,
  parameter  int NUM_BANKS  = 4,
  parameter  int GROUP_SIZE = 2,
  parameter  int CNT_W      = 8,
  localparam int NUM_GROUPS = NUM_BANKS / GROUP_SIZE,
  localparam int AW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [AW-1:0]               wr_addr,
  input  logic                        wr_bcast,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [NUM_GROUPS-1:0]       lock_set,
  output logic [NUM_GROUPS-1:0]       lock_q,
  input  logic [AW-1:0]               rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic [NUM_BANKS*DATA_W-1:0] bank_q,
  output logic                        viol_pulse,
  output logic [CNT_W-1:0]            viol_cnt,
  input  logic                        viol_clr
);

  import lock_grp_pkg::*;

  if (NUM_BANKS % GROUP_SIZE != 0) begin : g_bad_group_size
    $error("NUM_BANKS must be a multiple of GROUP_SIZE");
  end

  wr_state_e             state_q;
  wr_state_e             state_d;
  logic [DATA_W-1:0]     bank [NUM_BANKS];
  logic [NUM_GROUPS-1:0] permit;
  logic [DATA_W-1:0]     rd_sel;
  logic                  wr_accept;
  logic                  addr_ok;
  logic                  grp_permit;
  logic                  wr_ok;
  logic                  viol;
  int unsigned           wr_grp;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_lock
    lock_grp_ctrl u_ctrl (
      .clk      (clk),
      .rst_n    (rst_n),
      .lock_set (lock_set[g]),
      .lock_q   (lock_q[g]),
      .permit   (permit[g])
    );
  end

  assign wr_ready  = (state_q == IDLE);
  assign wr_accept = wr_valid && wr_ready;
  assign addr_ok   = 32'(wr_addr) < NUM_BANKS;
  assign wr_grp    = grp_of(32'(wr_addr), GROUP_SIZE);
  assign wr_ok     = wr_accept && addr_ok && grp_permit;
  assign viol      = wr_accept && !(addr_ok && grp_permit);

  // Select the permit of the addressed group; no match means no permission
  always_comb begin
    grp_permit = 1'b0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (wr_grp == g) grp_permit = permit[g];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: one COMMIT cycle after each successful write
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_ok) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bank update: single bank or whole group at one edge, only within the addressed group
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) bank[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (grp_of(i, GROUP_SIZE) == wr_grp && (wr_bcast || 32'(wr_addr) == i)) begin
          bank[i] <= wr_data;
        end
      end
    end
  end

  // Violation pulse and saturating counter; clear wins over accumulation but not over a new hit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      viol_pulse <= 1'b0;
      viol_cnt   <= '0;
    end else begin
      viol_pulse <= viol;
      if (viol_clr) begin
        viol_cnt <= viol ? CNT_W'(1) : '0;
      end else if (viol && viol_cnt != {CNT_W{1'b1}}) begin
        viol_cnt <= viol_cnt + CNT_W'(1);
      end
    end
  end

  // Read mux; out-of-range addresses read as zero
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (32'(rd_addr) == i) rd_sel = bank[i];
    end
  end

  // Registered read port sees pre-write bank contents
  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_sel;
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_flat
    assign bank_q[i*DATA_W +: DATA_W] = bank[i];
  end

endmodule

// File: tb/tb_lock_grouped_reg_array.sv
// tb/tb_lock_grouped_reg_array.sv - directed vector bench for lock_grouped_reg_array
module tb_lock_grouped_reg_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic       wr_bcast;
  logic [1:0] wr_data;
  logic [1:0] lock_set;
  logic [1:0] lock_q;
  logic [1:0] rd_addr;
  logic [1:0] rd_data;
  logic [7:0] bank_q;
  logic       viol_pulse;
  logic [1:0] viol_cnt;
  logic       viol_clr;

  int total = 0;
  int bad   = 0;

  lock_grouped_reg_array #(
    .DATA_W(2), .NUM_BANKS(4), .GROUP_SIZE(2), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_bcast(wr_bcast), .wr_data(wr_data),
    .lock_set(lock_set), .lock_q(lock_q), .rd_addr(rd_addr), .rd_data(rd_data),
    .bank_q(bank_q), .viol_pulse(viol_pulse), .viol_cnt(viol_cnt), .viol_clr(viol_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    logic [1:0] wa;
    logic       wb;
    logic [1:0] wd;
    logic [1:0] ls;
    logic [1:0] ra;
    logic       vc;
    logic [7:0] e_bank;
    logic [1:0] e_lock;
    logic       e_rdy;
    logic       e_vp;
    logic [1:0] e_cnt;
    logic [1:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wv, input logic [1:0] wa, input logic wb,
                              input logic [1:0] wd, input logic [1:0] ls, input logic [1:0] ra,
                              input logic vc, input logic [7:0] e_bank, input logic [1:0] e_lock,
                              input logic e_rdy, input logic e_vp, input logic [1:0] e_cnt,
                              input logic [1:0] e_rd);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wb = wb; v.wd = wd; v.ls = ls; v.ra = ra; v.vc = vc;
    v.e_bank = e_bank; v.e_lock = e_lock; v.e_rdy = e_rdy; v.e_vp = e_vp;
    v.e_cnt = e_cnt; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_addr = 2'd0; wr_bcast = 1'b0; wr_data = 2'd0;
    lock_set = 2'b00; rd_addr = 2'd0; viol_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            wv wa    wb wd     ls     ra    vc  bank   lock  rdy vp cnt   rd
    // 1: plain write to bank1, read-during-write returns old value
    vecs.push_back(mk(1, 2'd1, 0, 2'b10, 2'b00, 2'd1, 0, 8'h08, 2'b00, 0, 0, 2'd0, 2'b00));
    vecs.push_back(mk(0, 2'd0, 0, 2'b00, 2'b00, 2'd1, 0, 8'h08, 2'b00, 1, 0, 2'd0, 2'b10));
    // 2: lock group 0, rejected write to bank0, group 1 still writable
    vecs.push_back(mk(0, 2'd0, 0, 2'b00, 2'b01, 2'd0, 0, 8'h08, 2'b01, 1, 0, 2'd0, 2'b00));
    vecs.push_back(mk(1, 2'd0, 0, 2'b11, 2'b00, 2'd2, 0, 8'h08, 2'b01, 1, 1, 2'd1, 2'b00));
    vecs.push_back(mk(1, 2'd2, 0, 2'b11, 2'b00, 2'd2, 0, 8'h38, 2'b01, 0, 0, 2'd1, 2'b00));
    vecs.push_back(mk(0, 2'd0, 0, 2'b00, 2'b00, 2'd2, 0, 8'h38, 2'b01, 1, 0, 2'd1, 2'b11));
    // 3: broadcast to group 1; then a write offered during COMMIT is not taken
    vecs.push_back(mk(1, 2'd2, 1, 2'b01, 2'b00, 2'd3, 0, 8'h58, 2'b01, 0, 0, 2'd1, 2'b00));
    vecs.push_back(mk(1, 2'd3, 0, 2'b11, 2'b00, 2'd3, 0, 8'h58, 2'b01, 1, 0, 2'd1, 2'b01));
    // 4: same-cycle lock and broadcast to group 1 is rejected
    vecs.push_back(mk(1, 2'd3, 1, 2'b10, 2'b10, 2'd1, 0, 8'h58, 2'b11, 1, 1, 2'd2, 2'b10));
    vecs.push_back(mk(0, 2'd0, 0, 2'b00, 2'b00, 2'd0, 0, 8'h58, 2'b11, 1, 0, 2'd2, 2'b00));
    // 5: counter saturates at 3, clear with violation gives 1, clear alone gives 0
    vecs.push_back(mk(1, 2'd0, 0, 2'b11, 2'b00, 2'd2, 0, 8'h58, 2'b11, 1, 1, 2'd3, 2'b01));
    vecs.push_back(mk(1, 2'd0, 0, 2'b11, 2'b00, 2'd2, 0, 8'h58, 2'b11, 1, 1, 2'd3, 2'b01));
    vecs.push_back(mk(1, 2'd1, 0, 2'b11, 2'b00, 2'd2, 0, 8'h58, 2'b11, 1, 1, 2'd3, 2'b01));
    vecs.push_back(mk(1, 2'd0, 0, 2'b11, 2'b00, 2'd2, 1, 8'h58, 2'b11, 1, 1, 2'd1, 2'b01));
    vecs.push_back(mk(0, 2'd0, 0, 2'b00, 2'b00, 2'd3, 1, 8'h58, 2'b11, 1, 0, 2'd0, 2'b01));

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset bank_q",     32'(bank_q),     32'h00);
    check("reset lock_q",     32'(lock_q),     32'h0);
    check("reset wr_ready",   32'(wr_ready),   32'h1);
    check("reset viol_pulse", 32'(viol_pulse), 32'h0);
    check("reset viol_cnt",   32'(viol_cnt),   32'h0);
    check("reset rd_data",    32'(rd_data),    32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_bcast = vecs[i].wb;
      wr_data  = vecs[i].wd; lock_set = vecs[i].ls; rd_addr = vecs[i].ra;
      viol_clr = vecs[i].vc;
      tick();
      check($sformatf("v%0d bank_q", i),     32'(bank_q),     32'(vecs[i].e_bank));
      check($sformatf("v%0d lock_q", i),     32'(lock_q),     32'(vecs[i].e_lock));
      check($sformatf("v%0d wr_ready", i),   32'(wr_ready),   32'(vecs[i].e_rdy));
      check($sformatf("v%0d viol_pulse", i), 32'(viol_pulse), 32'(vecs[i].e_vp));
      check($sformatf("v%0d viol_cnt", i),   32'(viol_cnt),   32'(vecs[i].e_cnt));
      check($sformatf("v%0d rd_data", i),    32'(rd_data),    32'(vecs[i].e_rd));
    end
    idle_inputs();

    // 6: one-cycle reset clears locks and banks; group 0 writable again
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst6 lock_q",   32'(lock_q),   32'h0);
    check("rst6 bank_q",   32'(bank_q),   32'h00);
    check("rst6 viol_cnt", 32'(viol_cnt), 32'h0);
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 2'b11;
    tick();
    wr_valid = 1'b0;
    check("rst6 write bank_q", 32'(bank_q), 32'h03);
    check("rst6 viol_pulse",   32'(viol_pulse), 32'h0);
    rd_addr = 2'd0;
    tick();
    check("rst6 rd_data", 32'(rd_data), 32'h3);

    // Reset asserted while in COMMIT returns to IDLE with everything cleared
    begin
      int waited = 0;
      while (!wr_ready && waited < 10) begin
        tick();
        waited++;
      end
      check("wait wr_ready", 32'(wr_ready), 32'h1);
    end
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 2'b01; lock_set = 2'b00;
    tick();
    wr_valid = 1'b0;
    check("commit wr_ready", 32'(wr_ready), 32'h0);
    check("commit bank_q",   32'(bank_q),   32'h07);
    lock_set = 2'b10;
    tick();
    lock_set = 2'b00;
    check("pre-rst lock_q", 32'(lock_q), 32'h2);
    wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 2'b10;
    tick();
    check("locked grp1 pulse", 32'(viol_pulse), 32'h1);
    wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 2'b10;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("second commit wr_ready", 32'(wr_ready), 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midcommit wr_ready", 32'(wr_ready), 32'h1);
    check("midcommit bank_q",   32'(bank_q),   32'h00);
    check("midcommit lock_q",   32'(lock_q),   32'h0);
    check("midcommit viol_cnt", 32'(viol_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
